// File: rtl/execute_branch_resolve_ctrl.sv
// Branch-resolution sequencer: on a mispredict it flushes the pipeline, redirects fetch
// and optionally writes the BTB; also keeps saturating hit/miss statistics.
module execute_branch_resolve_ctrl #(
  parameter int unsigned BTB_UPDATE_ENA = 1
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iSTATE_NORMAL,
  input  logic        iBR_VALID,
  input  logic        iBR_TAKEN,
  input  logic        iBR_IB,
  input  logic        iBR_PREDICT_HIT,
  input  logic [31:0] iBR_PC,
  input  logic [31:0] iBR_JUMP_ADDR,
  output logic        oBUSY,
  output logic        oFLUSH,
  output logic        oJUMP_VALID,
  output logic [31:0] oJUMP_ADDR,
  input  logic        iJUMP_ACK,
  output logic        oBTB_UPD_VALID,
  output logic [31:0] oBTB_UPD_PC,
  output logic [31:0] oBTB_UPD_TARGET,
  output logic        oBTB_UPD_TAKEN,
  input  logic        iBTB_UPD_BUSY,
  input  logic        iCOUNT_CLEAR,
  output logic [15:0] oHIT_COUNT,
  output logic [15:0] oMISS_COUNT
);

  typedef enum logic [1:0] {StIdle, StFlush, StJump, StUpdate} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic        taken_q, taken_d;
  logic        ib_q, ib_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        accept;

  assign accept = (state_q == StIdle) && iBR_VALID && iSTATE_NORMAL;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    jump_addr_d = jump_addr_q;
    taken_d     = taken_q;
    ib_d        = ib_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pc_d        = iBR_PC;
          target_d    = iBR_JUMP_ADDR;
          taken_d     = iBR_TAKEN;
          ib_d        = iBR_IB;
          // Redirect address is resolved at capture so oJUMP_ADDR comes straight from a flop.
          jump_addr_d = (iBR_TAKEN || iBR_IB) ? iBR_JUMP_ADDR : iBR_PC + 32'd4;
          if (!iBR_PREDICT_HIT) state_d = StFlush;
        end
      end
      StFlush: state_d = StJump;
      StJump: begin
        if (iJUMP_ACK) begin
          state_d = ((BTB_UPDATE_ENA != 0) && !ib_q) ? StUpdate : StIdle;
        end
      end
      StUpdate: begin
        if (!iBTB_UPD_BUSY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (iCOUNT_CLEAR) begin
      hit_cnt_d  = 16'h0000;
      miss_cnt_d = 16'h0000;
    end else if (accept) begin
      if (iBR_PREDICT_HIT) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q     <= StIdle;
      pc_q        <= 32'h0;
      target_q    <= 32'h0;
      jump_addr_q <= 32'h0;
      taken_q     <= 1'b0;
      ib_q        <= 1'b0;
      hit_cnt_q   <= 16'h0;
      miss_cnt_q  <= 16'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      jump_addr_q <= jump_addr_d;
      taken_q     <= taken_d;
      ib_q        <= ib_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign oBUSY           = (state_q != StIdle);
  assign oFLUSH          = (state_q == StFlush);
  assign oJUMP_VALID     = (state_q == StJump);
  assign oJUMP_ADDR      = jump_addr_q;
  assign oBTB_UPD_VALID  = (state_q == StUpdate);
  assign oBTB_UPD_PC     = pc_q;
  assign oBTB_UPD_TARGET = target_q;
  assign oBTB_UPD_TAKEN  = taken_q;
  assign oHIT_COUNT      = hit_cnt_q;
  assign oMISS_COUNT     = miss_cnt_q;

endmodule

// File: tb/tb_execute_branch_resolve_ctrl.sv
// Randomized bench for execute_branch_resolve_ctrl with a transaction-level reference model.
module tb_execute_branch_resolve_ctrl;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iSTATE_NORMAL, iBR_VALID, iBR_TAKEN, iBR_IB, iBR_PREDICT_HIT;
  logic [31:0] iBR_PC, iBR_JUMP_ADDR;
  logic        oBUSY, oFLUSH, oJUMP_VALID, iJUMP_ACK;
  logic [31:0] oJUMP_ADDR;
  logic        oBTB_UPD_VALID, oBTB_UPD_TAKEN, iBTB_UPD_BUSY, iCOUNT_CLEAR;
  logic [31:0] oBTB_UPD_PC, oBTB_UPD_TARGET;
  logic [15:0] oHIT_COUNT, oMISS_COUNT;

  int n_vec = 0;
  int n_err = 0;
  int hit_m = 0;
  int miss_m = 0;

  execute_branch_resolve_ctrl #(.BTB_UPDATE_ENA(1)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iSTATE_NORMAL(iSTATE_NORMAL),
    .iBR_VALID(iBR_VALID), .iBR_TAKEN(iBR_TAKEN), .iBR_IB(iBR_IB),
    .iBR_PREDICT_HIT(iBR_PREDICT_HIT), .iBR_PC(iBR_PC), .iBR_JUMP_ADDR(iBR_JUMP_ADDR),
    .oBUSY(oBUSY), .oFLUSH(oFLUSH), .oJUMP_VALID(oJUMP_VALID), .oJUMP_ADDR(oJUMP_ADDR),
    .iJUMP_ACK(iJUMP_ACK), .oBTB_UPD_VALID(oBTB_UPD_VALID), .oBTB_UPD_PC(oBTB_UPD_PC),
    .oBTB_UPD_TARGET(oBTB_UPD_TARGET), .oBTB_UPD_TAKEN(oBTB_UPD_TAKEN),
    .iBTB_UPD_BUSY(iBTB_UPD_BUSY), .iCOUNT_CLEAR(iCOUNT_CLEAR),
    .oHIT_COUNT(oHIT_COUNT), .oMISS_COUNT(oMISS_COUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Random activity on inputs that must be ignored while the controller is busy.
  task automatic junk();
    iBR_VALID       = 1'($urandom);
    iSTATE_NORMAL   = 1'($urandom);
    iBR_PREDICT_HIT = 1'($urandom);
    iBR_TAKEN       = 1'($urandom);
    iBR_IB          = 1'($urandom);
    iBR_PC          = $urandom;
    iBR_JUMP_ADDR   = $urandom;
  endtask

  task automatic check_counts();
    check_eq("hit_count", 32'(oHIT_COUNT), 32'(hit_m));
    check_eq("miss_count", 32'(oMISS_COUNT), 32'(miss_m));
  endtask

  task automatic do_hit(input logic normal);
    iBR_VALID = 1'b1; iSTATE_NORMAL = normal; iBR_PREDICT_HIT = 1'b1;
    iBR_PC = $urandom; iBR_JUMP_ADDR = $urandom;
    iBR_TAKEN = 1'($urandom); iBR_IB = 1'($urandom);
    iJUMP_ACK = 1'($urandom); iBTB_UPD_BUSY = 1'($urandom);
    tick();
    if (normal) hit_m = sat_inc(hit_m);
    check_eq("hit_busy", 32'(oBUSY), 32'd0);
    check_eq("hit_flush", 32'(oFLUSH), 32'd0);
    check_eq("hit_jv", 32'(oJUMP_VALID), 32'd0);
    check_counts();
    iBR_VALID = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic ib, input int ack_dly, input int busy_dly);
    logic [31:0] exp_addr;
    bit          do_upd;
    exp_addr = (tk || ib) ? tgt : pc + 32'd4;
    do_upd   = !ib;
    iBR_VALID = 1'b1; iSTATE_NORMAL = 1'b1; iBR_PREDICT_HIT = 1'b0;
    iBR_PC = pc; iBR_JUMP_ADDR = tgt; iBR_TAKEN = tk; iBR_IB = ib;
    iJUMP_ACK = 1'($urandom); iBTB_UPD_BUSY = 1'($urandom);
    check_eq("idle_busy", 32'(oBUSY), 32'd0);
    tick();
    miss_m = sat_inc(miss_m);
    check_eq("flush", 32'(oFLUSH), 32'd1);
    check_eq("flush_busy", 32'(oBUSY), 32'd1);
    check_eq("flush_jv", 32'(oJUMP_VALID), 32'd0);
    check_counts();
    junk();
    iJUMP_ACK = 1'($urandom);
    tick();
    for (int k = 0; k <= ack_dly; k++) begin
      check_eq("jump_valid", 32'(oJUMP_VALID), 32'd1);
      check_eq("jump_addr", oJUMP_ADDR, exp_addr);
      check_eq("jump_flush", 32'(oFLUSH), 32'd0);
      check_eq("jump_upd", 32'(oBTB_UPD_VALID), 32'd0);
      junk();
      iJUMP_ACK = (k == ack_dly);
      iBTB_UPD_BUSY = 1'($urandom);
      tick();
    end
    if (do_upd) begin
      for (int k = 0; k <= busy_dly; k++) begin
        check_eq("upd_valid", 32'(oBTB_UPD_VALID), 32'd1);
        check_eq("upd_pc", oBTB_UPD_PC, pc);
        check_eq("upd_target", oBTB_UPD_TARGET, tgt);
        check_eq("upd_taken", 32'(oBTB_UPD_TAKEN), 32'(tk));
        check_eq("upd_jv", 32'(oJUMP_VALID), 32'd0);
        junk();
        iJUMP_ACK = 1'($urandom);
        iBTB_UPD_BUSY = (k < busy_dly);
        tick();
      end
    end
    check_eq("end_busy", 32'(oBUSY), 32'd0);
    check_eq("end_upd", 32'(oBTB_UPD_VALID), 32'd0);
    check_counts();
    iBR_VALID = 1'b0;
  endtask

  initial begin
    inRESET = 1'b0; iSTATE_NORMAL = 1'b0; iBR_VALID = 1'b0; iBR_TAKEN = 1'b0;
    iBR_IB = 1'b0; iBR_PREDICT_HIT = 1'b0; iBR_PC = '0; iBR_JUMP_ADDR = '0;
    iJUMP_ACK = 1'b0; iBTB_UPD_BUSY = 1'b0; iCOUNT_CLEAR = 1'b0;
    #1;
    check_eq("rst_busy", 32'(oBUSY), 32'd0);
    check_eq("rst_flush", 32'(oFLUSH), 32'd0);
    check_eq("rst_jv", 32'(oJUMP_VALID), 32'd0);
    check_eq("rst_uv", 32'(oBTB_UPD_VALID), 32'd0);
    check_eq("rst_ut", 32'(oBTB_UPD_TAKEN), 32'd0);
    check_eq("rst_jaddr", oJUMP_ADDR, 32'd0);
    check_eq("rst_upc", oBTB_UPD_PC, 32'd0);
    check_eq("rst_utgt", oBTB_UPD_TARGET, 32'd0);
    check_counts();
    repeat (2) @(posedge iCLOCK);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    tick();

    do_hit(1'b1);
    do_miss(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0, 2, 0);
    do_miss(32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0, 0, 2);
    do_miss(32'h0000_3000, 32'h0000_4000, 1'b0, 1'b1, 1, 0);
    do_hit(1'b0);

    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 5);
      if (r == 0)      do_hit(1'b1);
      else if (r == 1) do_hit(1'b0);
      else do_miss($urandom, $urandom, 1'($urandom), ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Clear, then drive the hit counter into saturation.
    iCOUNT_CLEAR = 1'b1; tick(); iCOUNT_CLEAR = 1'b0;
    hit_m = 0; miss_m = 0;
    check_counts();
    iBR_VALID = 1'b1; iSTATE_NORMAL = 1'b1; iBR_PREDICT_HIT = 1'b1;
    repeat (65540) @(posedge iCLOCK);
    #1;
    hit_m = 65535;
    check_eq("hit_sat", 32'(oHIT_COUNT), 32'h0000_FFFF);
    iCOUNT_CLEAR = 1'b1;
    tick();
    iCOUNT_CLEAR = 1'b0; iBR_VALID = 1'b0;
    hit_m = 0;
    check_eq("clear_vs_hit", 32'(oHIT_COUNT), 32'd0);
    do_miss(32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 0, 0);

    // Reset while in JUMP aborts the sequence at once.
    iBR_VALID = 1'b1; iSTATE_NORMAL = 1'b1; iBR_PREDICT_HIT = 1'b0; iJUMP_ACK = 1'b0;
    iBR_PC = 32'h0000_5000; iBR_JUMP_ADDR = 32'h0000_6000; iBR_TAKEN = 1'b1; iBR_IB = 1'b0;
    tick();
    iBR_VALID = 1'b0;
    tick();
    check_eq("pre_rst_jv", 32'(oJUMP_VALID), 32'd1);
    inRESET = 1'b0;
    #1;
    hit_m = 0; miss_m = 0;
    check_eq("rst_mid_jv", 32'(oJUMP_VALID), 32'd0);
    check_eq("rst_mid_busy", 32'(oBUSY), 32'd0);
    check_counts();
    @(negedge iCLOCK);
    inRESET = 1'b1;
    iBR_VALID = 1'b1; iSTATE_NORMAL = 1'b1; iBR_PREDICT_HIT = 1'b1;
    tick();
    hit_m = 1;
    check_eq("post_rst_busy", 32'(oBUSY), 32'd0);
    check_counts();
    iBR_VALID = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
